iter_divider: RTL and testbench

- Multi-cycle signed integer divider for the processor datapath, the inverse of the adder/multiplier arithmetic path.
- Performs restoring shift-subtract division, one quotient bit per cycle, reusing a WIDTH-bit subtract per iteration.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy and resumes on data_resultRDY.

---
 rtl/iter_divider.sv | 144 ++++++++++++++
 tb/tb_iter_divider.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per cycle, sign fix-up afterwards.
// Start pulse samples operands; a start while busy aborts and restarts with the new operands.
module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_quotient,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] magb_q, magb_d;
   logic             sgnq_q, sgnq_d;
   logic             sgnr_q, sgnr_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;

   // Magnitudes are unsigned, so |most-negative| = 2^(WIDTH-1) still fits in WIDTH bits.
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   shifted;
   logic             trial_ge;
   logic [WIDTH-1:0] diff;

   assign mag_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign mag_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign shifted  = {rem_q, quo_q[WIDTH-1]};
   assign trial_ge = shifted >= {1'b0, magb_q};
   assign diff     = shifted[WIDTH-1:0] - magb_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      magb_d  = magb_q;
      sgnq_d  = sgnq_q;
      sgnr_d  = sgnr_q;
      div0_d  = div0_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
      busy_d  = busy_q;

      case (state_q)
         S_RUN: begin
            rem_d = trial_ge ? diff : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], trial_ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            quot_d  = sgnq_q ? -quo_q : quo_q;
            remo_d  = sgnr_q ? -rem_q : rem_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (div0_q) begin
               quot_d = '0;
               remo_d = '0;
               exc_d  = 1'b1;
            end
         end
         default: ;
      endcase

      // A start in DONE lets the finishing result (and its exception) complete.
      if (ctrl_DIV) begin
         magb_d  = mag_b;
         sgnq_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         sgnr_d  = data_operandA[WIDTH-1];
         div0_d  = (data_operandB == '0);
         cnt_d   = '0;
         rem_d   = '0;
         quo_d   = mag_a;
         busy_d  = 1'b1;
         exc_d   = (state_q == S_DONE) ? div0_q : 1'b0;
         state_d = (data_operandB == '0) ? S_DONE : S_RUN;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         magb_q  <= '0;
         sgnq_q  <= 1'b0;
         sgnr_q  <= 1'b0;
         div0_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         magb_q  <= magb_d;
         sgnq_q  <= sgnq_d;
         sgnr_q  <= sgnr_d;
         div0_q  <= div0_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign data_quotient  = quot_q;
   assign data_remainder = remo_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed corner cases plus random operands against a
// plain-arithmetic signed division model.
module tb_iter_divider;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         ctrl_DIV = 1'b0;
   logic [W-1:0] data_operandA = '0;
   logic [W-1:0] data_operandB = '0;
   logic [W-1:0] data_quotient, data_remainder;
   logic         data_exception, data_resultRDY, busy;

   int n_checks = 0;
   int n_pass   = 0;

   iter_divider #(.WIDTH(W)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .ctrl_DIV      (ctrl_DIV),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .data_quotient (data_quotient),
      .data_remainder(data_remainder),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Truncating signed division; 64-bit math makes MIN/-1 wrap naturally when cut to 32 bits.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic e);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 0) begin
         q = '0; r = '0; e = 1'b1;
      end else begin
         q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
      end
   endfunction

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(negedge clock);
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      logic        ee;
      int          lat;
      ref_div(a, b, eq, er, ee);
      start(a, b);
      chk("busy_after_start", 32'(busy), 32'd1);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!data_resultRDY && lat < 100);
      chk("rdy_latency", 32'(lat), (b == 0) ? 32'd1 : 32'(W + 2));
      chk("quotient", data_quotient, eq);
      chk("remainder", data_remainder, er);
      chk("exception", 32'(data_exception), 32'(ee));
      chk("busy_at_rdy", 32'(busy), 32'd0);
      @(negedge clock);
      chk("rdy_one_cycle", 32'(data_resultRDY), 32'd0);
      chk("quotient_hold", data_quotient, eq);
   endtask

   task automatic chk_reset_vals();
      chk("rst_quotient", data_quotient, 32'd0);
      chk("rst_remainder", data_remainder, 32'd0);
      chk("rst_exception", 32'(data_exception), 32'd0);
      chk("rst_rdy", 32'(data_resultRDY), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 9))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd0;
         3:       return 32'd1;
         4, 5:    return 32'($signed($urandom_range(0, 200)) - 100);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      chk_reset_vals();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      do_op(32'd100, 32'd7);
      do_op(-32'sd100, 32'd7);
      do_op(32'd100, -32'sd7);
      do_op(-32'sd100, -32'sd7);
      do_op(32'd55, 32'd0);
      do_op(32'd9, 32'd3);
      do_op(32'h8000_0000, 32'hFFFF_FFFF);
      do_op(32'h8000_0000, 32'd1);
      do_op(32'd7, 32'd100);

      // Abort: restart after 10 cycles, only the second operation may report.
      start(32'd1000, 32'd10);
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         chk("no_rdy_before_abort", 32'(data_resultRDY), 32'd0);
      end
      do_op(32'd17, 32'd5);

      // Reset mid-run clears everything immediately.
      start(32'd12345, 32'd67);
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         chk("no_rdy_before_reset", 32'(data_resultRDY), 32'd0);
      end
      reset_n = 1'b0;
      #1;
      chk_reset_vals();
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (data_resultRDY) chk("no_rdy_after_reset", 32'(data_resultRDY), 32'd0);
      end
      do_op(32'd8, 32'd2);

      for (int i = 0; i < 30; i++) begin
         logic [31:0] a, b;
         a = pick_operand();
         b = pick_operand();
         do_op(a, b);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
